// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples ss/sck/mosi in the clk domain and exchanges
// one WIDTH-bit word (MSB first) per frame in each direction, in any CPOL/CPHA
// mode. Words may follow back to back inside one ss-low frame.
//
// Host-side handshake: we is a single-cycle strobe with no backpressure. It
// loads tx_data into tx_buf and clears tx_ready. tx_ready returns to 1 when
// tx_buf is copied into the shift register, either at frame start or at a word
// boundary. If nothing new is written before the next copy, the old tx_buf is
// sent again. done is a one-cycle strobe that marks a new value on rx_data.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             we,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             done,
  output logic             busy,
  output logic             fsm_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   ss_s;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   sck_d;
  logic                   ss_d;
  logic                   ss_fall;
  logic                   start;
  logic                   active;
  logic                   lead;
  logic                   trail;
  logic                   sample;
  logic                   drive;
  logic                   last;
  logic                   cpol_l;
  logic                   cpha_l;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       rx_sr;
  logic [WIDTH-1:0]       tx_sr;
  logic [WIDTH-1:0]       tx_buf;
  logic                   miso_q;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchronise the pins. fill tracks when the chain holds real pin samples
  // rather than reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      fill      <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Hold the previous synchronised samples for edge detection. ss_d stays 0
  // until the chain carries a real high ss, so an ss that is already low at
  // reset release does not start a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_d <= 1'b0;
      ss_d  <= 1'b0;
    end else begin
      sck_d <= sck_s;
      ss_d  <= fill[SYNC_STAGES-1] & ss_s;
    end
  end

  assign ss_fall = ss_d & ~ss_s;

  // Register the frame state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Decide the next frame state. busy follows ss so that it rises in the start
  // cycle and drops in the same cycle as an abort.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
          busy      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) state_nxt = IDLE;
        else      busy      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign miso_oe   = busy;
  assign fsm_state = state;
  assign miso      = miso_oe ? miso_q : 1'bz;

  assign active = (state == ACTIVE) && !ss_s;
  assign lead   = active && (sck_d == cpol_l) && (sck_s != cpol_l);
  assign trail  = active && (sck_d != cpol_l) && (sck_s == cpol_l);
  assign sample = cpha_l ? trail : lead;
  assign drive  = cpha_l ? lead : trail;
  assign last   = sample && (bit_cnt == CW'(WIDTH - 1));

  // Datapath: shift registers, bit counter, tx buffer and rx word. For CPHA=0
  // the MSB goes out at frame start, so tx_sr keeps only the bits that are
  // still to be driven. Each trailing edge then presents tx_sr's MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      tx_buf   <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      done     <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cpol_l   <= cpol;
        cpha_l   <= cpha;
        bit_cnt  <= '0;
        miso_q   <= tx_buf[WIDTH-1];
        tx_sr    <= cpha ? tx_buf : {tx_buf[WIDTH-2:0], 1'b0};
        tx_ready <= 1'b1;
      end else begin
        if (drive) begin
          miso_q <= tx_sr[WIDTH-1];
          tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
        end
        if (sample) begin
          rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
          if (last) begin
            bit_cnt  <= '0;
            rx_data  <= {rx_sr[WIDTH-2:0], mosi_s};
            done     <= 1'b1;
            tx_sr    <= tx_buf;
            tx_ready <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
      if (we) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: a timed SPI master drives frames and captures miso.
// Each test checks the received words, the transmitted words and the status
// flags against values worked out from the data the bench wrote and sent.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 80;

  logic         clk;
  logic         rst_n;
  logic         ss;
  logic         sck;
  logic         mosi;
  wire          miso;
  logic         miso_oe;
  logic         cpol;
  logic         cpha;
  logic         we;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         done;
  logic         busy;
  logic         fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_buf;
  logic         ready_at_start;
  logic         oe_at_start;

  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst_n), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .we(we), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_data(rx_data), .done(done), .busy(busy),
    .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every received word together with its done strobe.
  always @(negedge clk) if (done) got_q.push_back(rx_data);

  task automatic write_tx(input logic [W-1:0] v);
    @(negedge clk);
    we = 1'b1;
    tx_data = v;
    @(negedge clk);
    we = 1'b0;
    model_buf = v;
  endtask

  // Run one SPI master frame of nbits (MSB first from the low nbits of mo).
  task automatic master_frame(input logic pol, input logic pha, input int nbits,
                              input logic [31:0] mo, output logic [31:0] mi);
    logic b;
    mi = '0;
    @(negedge clk);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = mo[nbits-1-i];
      if (!pha) begin
        mosi = b;
        #HALF;
        if (i == 0) begin
          ready_at_start = tx_ready;
          oe_at_start = miso_oe & busy;
        end
        mi = {mi[30:0], miso};
        sck = ~pol;
        #HALF;
        sck = pol;
      end else begin
        #HALF;
        sck = ~pol;
        mosi = b;
        if (i == 0) begin
          ready_at_start = tx_ready;
          oe_at_start = miso_oe & busy;
        end
        #HALF;
        mi = {mi[30:0], miso};
        sck = pol;
      end
    end
    #HALF;
    ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Compare recorded rx words against exp_q, then clear both.
  task automatic check_rx(input string name);
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s done_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
    end
    checks++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL %s rx_word%0d got=%h want=%h", name, k, got_q[k], exp_q[k]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    we = 1'b0; tx_data = '0; model_buf = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, miso_oe, done, tx_ready, fsm_state} !== 5'b00010 || rx_data !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b oe=%b done=%b rdy=%b st=%b rx=%h want 0,0,0,1,0,00",
               busy, miso_oe, done, tx_ready, fsm_state, rx_data);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [31:0] mi;
    write_tx(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL mode0_ready_after_write got=%b want=0", tx_ready);
    end
    master_frame(1'b0, 1'b0, 8, 32'h3C, mi);
    exp_q.push_back(8'h3C);
    check_rx("mode0");
    checks++;
    if (ready_at_start !== 1'b1 || oe_at_start !== 1'b1) begin
      failures++;
      $display("FAIL mode0_start_flags got rdy=%b oe=%b want 1,1", ready_at_start, oe_at_start);
    end
    checks++;
    if (mi[7:0] !== 8'hA5) begin
      failures++;
      $display("FAIL mode0_miso got=%h want=a5", mi[7:0]);
    end
  endtask

  task automatic test_mode3();
    logic [31:0] mi;
    write_tx(8'h81);
    master_frame(1'b1, 1'b1, 8, 32'hAA, mi);
    exp_q.push_back(8'hAA);
    check_rx("mode3");
    checks++;
    if (mi[7:0] !== 8'h81) begin
      failures++;
      $display("FAIL mode3_miso got=%h want=81", mi[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mi;
    int waited;
    write_tx(8'h12);
    fork
      master_frame(1'b0, 1'b1, 16, 32'hF00F, mi);
      begin
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        checks++;
        if (waited >= 200) begin
          failures++;
          $display("FAIL b2b_ready_timeout got=%b want=1", tx_ready);
        end
        write_tx(8'h34);
      end
    join
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    check_rx("b2b");
    checks++;
    if (mi[15:0] !== 16'h1234) begin
      failures++;
      $display("FAIL b2b_miso got=%h want=1234", mi[15:0]);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_end got=%b want=1", tx_ready);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] mi;
    write_tx(8'h12);
    master_frame(1'b0, 1'b1, 16, 32'hF00F, mi);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    check_rx("underrun");
    checks++;
    if (mi[15:0] !== 16'h1212 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL underrun_miso got=%h rdy=%b want=1212 rdy=1", mi[15:0], tx_ready);
    end
  endtask

  task automatic test_abort();
    logic [31:0] mi;
    logic [W-1:0] prev;
    prev = rx_data;
    master_frame(1'b0, 1'b0, 5, 32'h15, mi);
    check_rx("abort");
    checks++;
    if (rx_data !== 8'h0F || busy !== 1'b0 || miso_oe !== 1'b0 || oe_at_start !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got rx=%h busy=%b oe=%b oe_mid=%b want rx=0f busy=0 oe=0 oe_mid=1",
               rx_data, busy, miso_oe, oe_at_start);
    end
    master_frame(1'b0, 1'b0, 8, 32'h5A, mi);
    exp_q.push_back(8'h5A);
    check_rx("after_abort");
    checks++;
    if (mi[7:0] !== model_buf || rx_data === prev) begin
      failures++;
      $display("FAIL after_abort_miso got=%h rx=%h want=%h rx!=%h", mi[7:0], rx_data, model_buf, prev);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] mi;
    fork
      master_frame(1'b0, 1'b0, 8, 32'hE7, mi);
      begin
        #(40 + 3 * 2 * HALF + 40);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_buf = '0;
        #1;
        checks++;
        if ({busy, miso_oe, done, tx_ready} !== 4'b0001 || rx_data !== '0) begin
          failures++;
          $display("FAIL async_reset got busy=%b oe=%b done=%b rdy=%b rx=%h want 0,0,0,1,00",
                   busy, miso_oe, done, tx_ready, rx_data);
        end
        #(2 * 2 * HALF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ss !== 1'b0) begin
          failures++;
          $display("FAIL ss_low_at_release got busy=%b ss=%b want busy=0 ss=0", busy, ss);
        end
      end
    join
    check_rx("reset_mid");
    master_frame(1'b1, 1'b0, 8, 32'hC3, mi);
    exp_q.push_back(8'hC3);
    check_rx("post_reset");
    checks++;
    if (mi[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_miso got=%h want=00", mi[7:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] mi;
    logic [31:0] mo;
    logic [31:0] want_mi;
    logic pol, pha;
    int n;
    for (int it = 0; it < 6; it++) begin
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      mo  = $urandom();
      if ($urandom_range(0, 1) == 1) write_tx(8'($urandom()));
      want_mi = '0;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(8'(mo >> (8 * (n - 1 - k))));
        want_mi = {want_mi[23:0], model_buf};
      end
      master_frame(pol, pha, n * 8, mo, mi);
      check_rx("random");
      checks++;
      if (mi !== want_mi || tx_ready !== 1'b1) begin
        failures++;
        $display("FAIL random_miso it=%0d mode=%b%b got=%h rdy=%b want=%h rdy=1",
                 it, pol, pha, mi, tx_ready, want_mi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI peripheral-side (slave) endpoint, the responder to the SPI master. It oversamples ss/sck/mosi in the system clock domain, supports all four CPOL/CPHA modes, and shifts a WIDTH-bit word in both directions per frame. It has a single-entry transmit holding buffer with a ready flag and a received-word register with a one-cycle done strobe. It sits at the chip boundary, and miso is tristated when the slave is not selected.

Parameters:
WIDTH, 8, bits per transfer word (MSB first)
SYNC_STAGES, 2, flip-flop stages on ss/sck/mosi synchronisers (≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
ss  input  1  slave select from master, active-low
sck  input  1  serial clock from master (asynchronous to clk)
mosi  input  1  serial data from master
miso  output  1  serial data to master; high-Z when miso_oe=0
miso_oe  output  1  1 while synchronised ss is low
cpol  input  1  clock idle level, latched at frame start
cpha  input  1  clock phase, latched at frame start
we  input  1  1-cycle write strobe: tx_data -> tx_buf
tx_data  input  WIDTH  word to transmit
tx_ready  output  1  1 = tx_buf consumed, new write expected
rx_data  output  WIDTH  last complete received word, held until next done
done  output  1  1-cycle pulse when rx_data updates
busy  output  1  frame active (synchronised ss low)

Behaviour:
- Reset (rst=0, async): miso_q=0, miso_oe=0, busy=0, done=0, rx_data=0, tx_buf=0, tx_ready=1, bit_cnt=0, state IDLE, sync chains are cleared to idle (ss=1, sck=0, mosi=0).
- ss, sck and mosi pass through SYNC_STAGES flops. sck edges are detected from the last two synchronised samples. Leading edge = departure from the latched cpol level; trailing edge = return to it.
- Constraint: the sck half-period must be ≥4 clk periods (sck ≤ clk/8). Faster sck is undefined.
- IDLE -> ACTIVE on synchronised ss falling:
  - latch cpol and cpha;
  - tx_sr <= tx_buf; tx_ready <= 1; bit_cnt <= 0;
  - miso_q <= tx_buf[WIDTH-1];
  - busy=1 and miso_oe=1 from this cycle.
- CPHA=0 in ACTIVE:
  - leading edge: sample mosi into rx_sr, increment bit_cnt;
  - trailing edge: shift tx_sr left and drive the next MSB on miso_q.
- CPHA=1 in ACTIVE:
  - leading edge: miso_q <= tx_sr[MSB] and shift tx_sr;
  - trailing edge: sample mosi and increment bit_cnt.
- Word complete (WIDTH-th sample):
  - rx_data <= {rx_sr[WIDTH-2:0], mosi} and done=1 for exactly one cycle;
  - bit_cnt <= 0; tx_sr <= tx_buf; tx_ready <= 1.
  - CPHA=0: the next trailing edge drives the new MSB. CPHA=1: the next leading edge drives it.
  - Result: back-to-back words with no gap.
- we: tx_buf <= tx_data and tx_ready <= 0, accepted in any state.
  - we and reload in the same cycle: the reload takes the old tx_buf, the new value is retained, and tx_ready=0.
- Underrun (reload while tx_ready=1): the stale tx_buf is resent. There is no error flag.
- ss rises mid-word (synchronised): abort and go to IDLE. Partial bits are discarded, no done, rx_data unchanged, miso_oe=0 and busy=0 the same cycle. tx_buf is unchanged.
- ss low at reset release: a frame starts only on a subsequent ss falling edge.
- cpol/cpha changes during ACTIVE are ignored until the next frame.
- Latency: done is asserted ≤SYNC_STAGES+2 clk after the sck edge that carries the last bit.

Test Plan:
1. Mode 0, clk 10 ns, sck 160 ns. we with tx_data=0xA5, then master sends 0x3C -> tx_ready=1 at ss fall; one done pulse; rx_data=0x3C; master captures 0xA5.
2. Mode 3 (cpol=1, cpha=1). tx 0x81, mosi 0xAA -> rx_data=0xAA, master reads 0x81, sck idles high.
3. Mode 1 back-to-back. Write 0x12; after tx_ready rises, write 0x34; master sends 0xF0,0x0F in one frame -> done twice; rx_data=0xF0 then 0x0F; miso 0x12 then 0x34.
4. Underrun. As scenario 3 without the second write -> second word on miso is 0x12; tx_ready stays 1.
5. Abort: ss high after 5 bits -> no done, rx_data unchanged, busy/miso_oe=0, miso=Z. Next frame of 0x5A -> rx_data=0x5A, correctly aligned.
6. rst=0 mid-word (async, between clk edges) -> all outputs at reset values immediately; after release, a new frame of 0xC3 -> rx_data=0xC3.
